// File: rtl/cpu_trace_pkg.sv
// Shared constants and entry layout for the multi-channel CPU trace buffer.
package cpu_trace_pkg;

  localparam int unsigned TRACE_PKG_W = 256;
  localparam int unsigned TRACE_GAP_W = 16;

  // Privilege level lives in package bits [254:253].
  localparam int unsigned PRV_LSB = 253;
  localparam int unsigned PRV_W   = 2;

  // FIFO entry: the package plus the number of drops that preceded it.
  typedef struct packed {
    logic [TRACE_PKG_W-1:0] pkg;
    logic [TRACE_GAP_W-1:0] gap;
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_fifo.sv
// Single-channel synchronous FIFO with registered count, full and empty.
module cpu_trace_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Next pointers and flags; a push is refused on the registered full flag.
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cpu_trace_buf.sv
// Per-hart trace capture FIFOs with drop counting and a round-robin output stage.
module cpu_trace_buf
  import cpu_trace_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PKG_W = TRACE_PKG_W,
  parameter int unsigned GAP_W = TRACE_GAP_W
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     trace_en,
  input  logic [3:0]               prv_mask,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*PKG_W-1:0]     in_pkg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKG_W-1:0]         out_pkg,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [GAP_W-1:0]         out_gap,
  output logic [NCH-1:0]           ovf_sticky,
  input  logic                     ovf_clr
);

  localparam int unsigned CH_W  = $clog2(NCH);
  localparam int unsigned ENT_W = PKG_W + GAP_W;

  // Same layout as trace_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PKG_W-1:0] pkg;
    logic [GAP_W-1:0] gap;
  } entry_t;

  logic [NCH-1:0]            cap, push, drop, pop, full, empty;
  entry_t [NCH-1:0]          wdata, rdata;
  logic [NCH-1:0][GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [NCH-1:0]            ovf_q, ovf_d;

  logic              out_valid_q, out_valid_d;
  logic [PKG_W-1:0]  out_pkg_q, out_pkg_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [GAP_W-1:0]  out_gap_q, out_gap_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   sel;
  logic              found, load;
  int unsigned       idx;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PKG_W-1:0] pkg_c;
    logic [PRV_W-1:0] prv_c;

    // Capture filter, then push or drop depending on the registered full flag.
    assign pkg_c    = in_pkg[c*PKG_W +: PKG_W];
    assign prv_c    = pkg_c[PRV_LSB +: PRV_W];
    assign cap[c]   = in_valid[c] && trace_en && prv_mask[prv_c];
    assign push[c]  = cap[c] && !full[c];
    assign drop[c]  = cap[c] && full[c];
    assign wdata[c] = {pkg_c, gap_cnt_q[c]};

    cpu_trace_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .srst_i  (srst),
      .push_i  (push[c]),
      .wdata_i (wdata[c]),
      .pop_i   (pop[c]),
      .rdata_o (rdata[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  // Drop counters clear on a push and saturate on drops; a drop beats ovf_clr.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (push[c]) begin
        gap_cnt_d[c] = '0;
      end else if (drop[c] && (gap_cnt_q[c] != '1)) begin
        gap_cnt_d[c] = gap_cnt_q[c] + GAP_W'(1);
      end
    end
    ovf_d = (ovf_clr ? '0 : ovf_q) | drop;
  end

  // Round-robin pick starting after the last grant; output loads when free or accepted.
  always_comb begin
    load        = !out_valid_q || out_ready;
    found       = 1'b0;
    sel         = grant_q;
    idx         = 0;
    pop         = '0;
    out_valid_d = out_valid_q;
    out_pkg_d   = out_pkg_q;
    out_ch_d    = out_ch_q;
    out_gap_d   = out_gap_q;
    grant_d     = grant_q;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = 32'(grant_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && !empty[CH_W'(idx)]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    if (load) begin
      out_valid_d = found;
      if (found) begin
        pop[sel]  = 1'b1;
        out_pkg_d = rdata[sel].pkg;
        out_gap_d = rdata[sel].gap;
        out_ch_d  = sel;
        grant_d   = sel;
      end
    end
  end

  // Output stage, grant pointer, drop counters and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_q <= 1'b0;
      out_pkg_q   <= '0;
      out_ch_q    <= '0;
      out_gap_q   <= '0;
      grant_q     <= CH_W'(NCH - 1);
      gap_cnt_q   <= '0;
      ovf_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkg_q   <= out_pkg_d;
      out_ch_q    <= out_ch_d;
      out_gap_q   <= out_gap_d;
      grant_q     <= grant_d;
      gap_cnt_q   <= gap_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pkg    = out_pkg_q;
  assign out_ch     = out_ch_q;
  assign out_gap    = out_gap_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_cpu_trace_buf.sv
// Scoreboard bench for cpu_trace_buf: queue-level reference model plus directed scenarios.
module tb_cpu_trace_buf;

  localparam int unsigned NCH     = 2;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PKG_W   = 256;
  localparam int unsigned GAP_W   = 4;
  localparam int          GAP_MAX = (1 << GAP_W) - 1;

  logic                 clk = 1'b0;
  logic                 srst;
  logic                 trace_en;
  logic [3:0]           prv_mask;
  logic [NCH-1:0]       in_valid;
  logic [NCH*PKG_W-1:0] in_pkg;
  logic                 out_valid;
  logic                 out_ready;
  logic [PKG_W-1:0]     out_pkg;
  logic [0:0]           out_ch;
  logic [GAP_W-1:0]     out_gap;
  logic [NCH-1:0]       ovf_sticky;
  logic                 ovf_clr;

  always #5 clk = ~clk;

  cpu_trace_buf #(
    .NCH   (NCH),
    .DEPTH (DEPTH),
    .PKG_W (PKG_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .trace_en   (trace_en),
    .prv_mask   (prv_mask),
    .in_valid   (in_valid),
    .in_pkg     (in_pkg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pkg    (out_pkg),
    .out_ch     (out_ch),
    .out_gap    (out_gap),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  typedef struct {
    int               ch;
    logic [PKG_W-1:0] pkg;
    logic [GAP_W-1:0] gap;
  } rec_t;

  rec_t sb_q[$];
  rec_t log_q[$];
  rec_t mq[NCH][$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [PKG_W-1:0] act, input logic [PKG_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queues per channel, one output slot ----------------
  int             m_gap [NCH];
  int             pre_sz[NCH];
  bit             m_ov;
  int             m_grant;
  int             pick;
  int             cand;
  logic [NCH-1:0] m_sticky;
  logic [NCH-1:0] m_drops;
  logic [PKG_W-1:0] m_pkg;
  bit             live = 1'b0;
  bit             rst_edge = 1'b0;
  rec_t           m_rec;

  always @(posedge clk) begin
    rst_edge = srst;
    if (srst) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_gap[c] = 0;
      end
      sb_q.delete();
      m_ov     = 1'b0;
      m_grant  = NCH - 1;
      m_sticky = '0;
      live     = 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) pre_sz[c] = mq[c].size();
      if (!m_ov || out_ready) begin
        pick = -1;
        for (int k = 1; k <= NCH; k++) begin
          cand = (m_grant + k) % NCH;
          if (pick < 0 && pre_sz[cand] > 0) pick = cand;
        end
        if (pick >= 0) begin
          m_rec = mq[pick].pop_front();
          sb_q.push_back(m_rec);
          m_ov    = 1'b1;
          m_grant = pick;
        end else begin
          m_ov = 1'b0;
        end
      end
      m_drops = '0;
      for (int c = 0; c < NCH; c++) begin
        m_pkg = in_pkg[c*PKG_W +: PKG_W];
        if (in_valid[c] && trace_en && prv_mask[m_pkg[254:253]]) begin
          if (pre_sz[c] >= DEPTH) begin
            m_drops[c] = 1'b1;
            if (m_gap[c] < GAP_MAX) m_gap[c] = m_gap[c] + 1;
          end else begin
            m_rec.ch  = c;
            m_rec.pkg = m_pkg;
            m_rec.gap = GAP_W'(m_gap[c]);
            mq[c].push_back(m_rec);
            m_gap[c] = 0;
          end
        end
      end
      m_sticky = (ovf_clr ? '0 : m_sticky) | m_drops;
    end
  end

  // ---------------- monitor ----------------
  bit               prev_stall = 1'b0;
  logic [PKG_W-1:0] prev_pkg;
  logic [0:0]       prev_ch;
  logic [GAP_W-1:0] prev_gap;
  rec_t             mon_rec;
  rec_t             got_rec;

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 256'(out_valid), 256'(m_ov));
      chk("ovf_sticky", 256'(ovf_sticky), 256'(m_sticky));
      if (prev_stall && !rst_edge) begin
        chk("stall_pkg", out_pkg, prev_pkg);
        chk("stall_ch", 256'(out_ch), 256'(prev_ch));
        chk("stall_gap", 256'(out_gap), 256'(prev_gap));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got ch %0d pkg %0h expected nothing", out_ch, out_pkg);
        end else begin
          mon_rec = sb_q.pop_front();
          chk("sb_ch", 256'(out_ch), 256'(mon_rec.ch));
          chk("sb_pkg", out_pkg, mon_rec.pkg);
          chk("sb_gap", 256'(out_gap), 256'(mon_rec.gap));
        end
        got_rec.ch  = int'(out_ch);
        got_rec.pkg = out_pkg;
        got_rec.gap = out_gap;
        log_q.push_back(got_rec);
      end
      prev_stall = out_valid && !out_ready;
      prev_pkg   = out_pkg;
      prev_ch    = out_ch;
      prev_gap   = out_gap;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [PKG_W-1:0] rnd_pkg(input logic [1:0] prv);
    logic [PKG_W-1:0] p;
    for (int w = 0; w < PKG_W / 32; w++) p[w*32 +: 32] = $urandom;
    p[254:253] = prv;
    return p;
  endfunction

  task automatic set_ch(input int c, input logic [PKG_W-1:0] p);
    in_valid[c]              = 1'b1;
    in_pkg[c*PKG_W +: PKG_W] = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PKG_W-1:0] p;
    logic [PKG_W-1:0] hold_pkg;
    logic [0:0]       hold_ch;
    logic [GAP_W-1:0] hold_gap;
    int               w;

    srst = 1'b1; trace_en = 1'b0; prv_mask = '0; in_valid = '0; in_pkg = '0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_pkg", out_pkg, '0);
    chk("rst_ch", 256'(out_ch), 256'(0));
    chk("rst_gap", 256'(out_gap), 256'(0));
    chk("rst_sticky", 256'(ovf_sticky), 256'(0));
    srst = 1'b0;

    // Single package, latency of two cycles.
    trace_en = 1'b1; prv_mask = 4'b1000; out_ready = 1'b1;
    tick(2);
    p = '0; p[7:0] = 8'hA5; p[254:253] = 2'b11;
    set_ch(0, p);
    tick(1);
    in_valid = '0;
    @(negedge clk);
    chk("lat_n1_valid", 256'(out_valid), 256'(0));
    tick(1);
    @(negedge clk);
    chk("lat_n2_valid", 256'(out_valid), 256'(1));
    chk("single_pkg", out_pkg, p);
    chk("single_ch", 256'(out_ch), 256'(0));
    chk("single_gap", 256'(out_gap), 256'(0));

    // Privilege filter: machine-mode packages masked off.
    tick(3);
    log_q.delete();
    prv_mask = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, rnd_pkg(2'b11));
      tick(1);
    end
    in_valid = '0;
    tick(5);
    chk("filt_no_out", 256'(log_q.size()), 256'(0));
    chk("filt_sticky", 256'(ovf_sticky), 256'(0));
    prv_mask = 4'b1111;
    set_ch(0, rnd_pkg(2'b00));
    tick(1);
    in_valid = '0;
    tick(4);
    chk("filt_after_cnt", 256'(log_q.size()), 256'(1));
    if (log_q.size() > 0) chk("filt_gap", 256'(log_q[0].gap), 256'(0));

    // Overflow: output slot held by ch0, then 11 packages on ch1 with no consumer.
    log_q.delete();
    out_ready = 1'b0;
    set_ch(0, rnd_pkg(2'b01));
    tick(1);
    in_valid = '0;
    for (int i = 0; i < 11; i++) begin
      set_ch(1, rnd_pkg(2'($urandom_range(0, 3))));
      tick(1);
    end
    in_valid = '0;
    tick(2);
    chk("ovf_sticky_set", 256'(ovf_sticky), 256'(2'b10));
    chk("ovf_head_ch", 256'(out_ch), 256'(0));
    out_ready = 1'b1;
    tick(3);
    p = rnd_pkg(2'b10);
    set_ch(1, p);
    tick(1);
    in_valid = '0;
    tick(15);
    chk("ovf_count", 256'(log_q.size()), 256'(10));
    if (log_q.size() == 10) begin
      chk("ovf_last_pkg", log_q[9].pkg, p);
      chk("ovf_last_gap", 256'(log_q[9].gap), 256'(3));
      chk("ovf_prev_gap", 256'(log_q[8].gap), 256'(0));
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 256'(ovf_sticky), 256'(0));

    // Round-robin: both channels push four packages together.
    tick(1);
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      set_ch(0, rnd_pkg(2'b11));
      set_ch(1, rnd_pkg(2'b00));
      tick(1);
    end
    in_valid = '0;
    tick(12);
    chk("rr_count", 256'(log_q.size()), 256'(8));
    for (int i = 0; i < 8 && i < log_q.size(); i++) chk("rr_ch", 256'(log_q[i].ch), 256'(i % 2));

    // Stall holds the output stage; reset then discards everything queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, rnd_pkg(2'b11));
      set_ch(1, rnd_pkg(2'b01));
      tick(1);
    end
    in_valid = '0;
    w = 0;
    while (!out_valid && w < 20) begin
      tick(1);
      w++;
    end
    chk("stall_has_valid", 256'(out_valid), 256'(1));
    @(negedge clk);
    hold_pkg = out_pkg; hold_ch = out_ch; hold_gap = out_gap;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      @(negedge clk);
      chk("hold_valid", 256'(out_valid), 256'(1));
      chk("hold_pkg", out_pkg, hold_pkg);
      chk("hold_ch", 256'(out_ch), 256'(hold_ch));
      chk("hold_gap", 256'(out_gap), 256'(hold_gap));
    end
    tick(1);
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 256'(out_valid), 256'(0));
    log_q.delete();
    out_ready = 1'b1;
    tick(10);
    chk("mid_rst_no_stale", 256'(log_q.size()), 256'(0));

    // Gap saturation: 20 drops into a 4-bit counter.
    out_ready = 1'b0;
    for (int i = 0; i < 29; i++) begin
      set_ch(0, rnd_pkg(2'b11));
      tick(1);
    end
    in_valid = '0;
    tick(1);
    chk("sat_sticky", 256'(ovf_sticky), 256'(2'b01));
    log_q.delete();
    out_ready = 1'b1;
    tick(4);
    p = rnd_pkg(2'b11);
    set_ch(0, p);
    tick(1);
    in_valid = '0;
    tick(15);
    chk("sat_count", 256'(log_q.size()), 256'(10));
    if (log_q.size() > 0) begin
      chk("sat_last_pkg", log_q[log_q.size()-1].pkg, p);
      chk("sat_last_gap", 256'(log_q[log_q.size()-1].gap), 256'(4'hF));
    end

    // Randomised traffic with bursts of backpressure, clears and enable toggling.
    for (int i = 0; i < 400; i++) begin
      trace_en = ($urandom_range(0, 9) != 0);
      prv_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      out_ready = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 2) != 0) set_ch(c, rnd_pkg(2'($urandom_range(0, 3))));
        else in_valid[c] = 1'b0;
      end
      tick(1);
    end
    ovf_clr = 1'b0;

    // Capture disabled: queued entries still drain.
    trace_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, rnd_pkg(2'($urandom_range(0, 3))));
      tick(1);
    end
    in_valid = '0;
    tick(2);
    @(negedge clk);
    chk("drain_sb_empty", 256'(sb_q.size()), 256'(0));
    chk("drain_valid", 256'(out_valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
